// File: rtl/aes_block_packer.sv
// Packs UART RX bytes into N-bit AES blocks (first byte in the MSBs) and offers
// each complete block over valid/ready. Partial blocks are dropped on line error or idle timeout.
module aes_block_packer #(
  parameter int N       = 128,
  parameter int BYTES   = N / 8,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_err,
  output logic [N-1:0]               blk_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [$clog2(BYTES):0]     byte_cnt,
  output logic [CNT_W-1:0]           blk_count,
  output logic                       ovf_pulse,
  output logic                       err_pulse,
  output logic                       tmo_pulse
);

  localparam int BC_W = $clog2(BYTES) + 1;
  localparam int IC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_HOLD
  } state_t;

  state_t            state_q;
  logic [N-1:0]      blk_data_q;
  logic              blk_valid_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [CNT_W-1:0]  blk_count_q;
  logic [IC_W-1:0]   idle_q;
  logic              ovf_q;
  logic              err_q;
  logic              tmo_q;

  logic good_byte;
  logic bad_byte;
  logic last_byte;
  logic idle_expired;

  assign good_byte    = rx_valid & ~rx_err;
  assign bad_byte     = rx_valid & rx_err;
  assign last_byte    = (byte_cnt_q == BC_W'(BYTES - 1));
  assign idle_expired = (idle_q == IC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      byte_cnt_q  <= '0;
      blk_count_q <= '0;
      idle_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        S_IDLE, S_FILL: begin
          if (good_byte) begin
            blk_data_q <= {blk_data_q[N-9:0], rx_data};
            byte_cnt_q <= byte_cnt_q + BC_W'(1);
            idle_q     <= '0;
            if (last_byte) begin
              state_q     <= S_HOLD;
              blk_valid_q <= 1'b1;
            end else begin
              state_q <= S_FILL;
            end
          end else if (bad_byte) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            err_q      <= 1'b1;
          end else if (state_q == S_FILL) begin
            // A byte on the expiry cycle takes the good_byte branch and wins.
            if (idle_expired) begin
              state_q    <= S_IDLE;
              byte_cnt_q <= '0;
              idle_q     <= '0;
              tmo_q      <= 1'b1;
            end else begin
              idle_q <= idle_q + IC_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (blk_ready) begin
            blk_valid_q <= 1'b0;
            blk_count_q <= blk_count_q + CNT_W'(1);
            idle_q      <= '0;
            if (good_byte) begin
              blk_data_q <= {blk_data_q[N-9:0], rx_data};
              byte_cnt_q <= BC_W'(1);
              state_q    <= S_FILL;
            end else begin
              byte_cnt_q <= '0;
              state_q    <= S_IDLE;
              err_q      <= bad_byte;
            end
          end else if (rx_valid) begin
            ovf_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          blk_valid_q <= 1'b0;
          byte_cnt_q  <= '0;
          idle_q      <= '0;
        end
      endcase
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign byte_cnt  = byte_cnt_q;
  assign blk_count = blk_count_q;
  assign ovf_pulse = ovf_q;
  assign err_pulse = err_q;
  assign tmo_pulse = tmo_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Scoreboard bench for aes_block_packer: expected blocks are queued by the
// stimulus and popped by a monitor at each valid/ready transfer.
module tb_aes_block_packer;

  localparam int N       = 128;
  localparam int BYTES   = 16;
  localparam int TIMEOUT = 1000;
  localparam int CNT_W   = 2;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_err;
  logic [N-1:0]      blk_data;
  logic              blk_valid;
  logic              blk_ready;
  logic [4:0]        byte_cnt;
  logic [CNT_W-1:0]  blk_count;
  logic              ovf_pulse;
  logic              err_pulse;
  logic              tmo_pulse;

  aes_block_packer #(
    .N(N), .BYTES(BYTES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .byte_cnt(byte_cnt), .blk_count(blk_count),
    .ovf_pulse(ovf_pulse), .err_pulse(err_pulse), .tmo_pulse(tmo_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ovf_seen = 0;
  int err_seen = 0;
  int tmo_seen = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Block scoreboard: compare at every transfer cycle.
  always @(negedge clk) begin
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_block: got %h expected none", blk_data);
      end else begin
        check("blk_data", blk_data, exp_q.pop_front());
      end
    end
    if (rst_n && ovf_pulse) ovf_seen++;
    if (rst_n && err_pulse) err_seen++;
    if (rst_n && tmo_pulse) tmo_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_valid = 1'b1;
    rx_err   = e;
    cycle();
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic put_block(input logic [7:0] first);
    for (int i = 0; i < BYTES; i++) put(first + 8'(i), 1'b0);
  endtask

  int ovf_base;

  initial begin
    rst_n     = 1'b0;
    rx_data   = '0;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    blk_ready = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    check("rst_blk_data",  blk_data, '0);
    check("rst_blk_valid", N'(blk_valid), '0);
    check("rst_byte_cnt",  N'(byte_cnt), '0);
    check("rst_blk_count", N'(blk_count), '0);
    check("rst_pulses",    N'({ovf_pulse, err_pulse, tmo_pulse}), '0);

    // Happy path
    exp_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
    put_block(8'h00);
    check("hp_valid", N'(blk_valid), 1);
    check("hp_byte_cnt", N'(byte_cnt), 16);
    cycle();
    check("hp_valid_drop", N'(blk_valid), 0);
    check("hp_blk_count", N'(blk_count), 1);
    check("hp_byte_cnt_after", N'(byte_cnt), 0);

    // Backpressure
    blk_ready = 1'b0;
    exp_q.push_back(128'h202122232425262728292A2B2C2D2E2F);
    put_block(8'h20);
    ovf_base = ovf_seen;
    put(8'h30, 1'b0);
    put(8'h31, 1'b0);
    put(8'h32, 1'b0);
    check("bp_frozen", blk_data, 128'h202122232425262728292A2B2C2D2E2F);
    check("bp_valid_held", N'(blk_valid), 1);
    blk_ready = 1'b1;
    put(8'hAA, 1'b0);
    check("bp_ovf_count", N'(ovf_seen - ovf_base), 3);
    check("bp_blk_count", N'(blk_count), 2);
    check("bp_byte_cnt", N'(byte_cnt), 1);
    check("bp_low_byte", N'(blk_data[7:0]), 8'hAA);
    check("bp_valid_drop", N'(blk_valid), 0);

    // Error mid-block (AA counts as the first of 5 good bytes)
    for (int i = 1; i < 5; i++) put(8'hA0 + 8'(i), 1'b0);
    check("err_pre_cnt", N'(byte_cnt), 5);
    put(8'h55, 1'b1);
    check("err_pulse", N'(err_pulse), 1);
    check("err_byte_cnt", N'(byte_cnt), 0);
    exp_q.push_back(128'h101112131415161718191A1B1C1D1E1F);
    put(8'h10, 1'b0);
    check("err_pulse_1cyc", N'(err_pulse), 0);
    for (int i = 1; i < BYTES; i++) put(8'h10 + 8'(i), 1'b0);
    check("err_blk_valid", N'(blk_valid), 1);
    cycle();
    check("err_blk_count", N'(blk_count), 3);

    // Timeout expiry
    for (int i = 0; i < 4; i++) put(8'hB0 + 8'(i), 1'b0);
    repeat (TIMEOUT - 1) cycle();
    check("tmo_not_yet", N'(tmo_pulse), 0);
    check("tmo_cnt_kept", N'(byte_cnt), 4);
    cycle();
    check("tmo_pulse", N'(tmo_pulse), 1);
    check("tmo_byte_cnt", N'(byte_cnt), 0);
    cycle();
    check("tmo_pulse_1cyc", N'(tmo_pulse), 0);

    // Byte on the expiry cycle wins
    for (int i = 0; i < 4; i++) put(8'hC0 + 8'(i), 1'b0);
    repeat (TIMEOUT - 1) cycle();
    put(8'hC4, 1'b0);
    check("tmo_win_pulse", N'(tmo_pulse), 0);
    check("tmo_win_cnt", N'(byte_cnt), 5);
    repeat (TIMEOUT - 1) cycle();
    check("tmo_restart_quiet", N'(tmo_pulse), 0);
    cycle();
    check("tmo_restart_pulse", N'(tmo_pulse), 1);

    // Error byte in HOLD, then transfer together with an error byte
    blk_ready = 1'b0;
    exp_q.push_back(128'h404142434445464748494A4B4C4D4E4F);
    put_block(8'h40);
    put(8'h99, 1'b1);
    check("hold_err_ovf", N'(ovf_pulse), 1);
    check("hold_err_noerr", N'(err_pulse), 0);
    check("hold_err_valid", N'(blk_valid), 1);
    blk_ready = 1'b1;
    put(8'h77, 1'b1);
    check("xfer_err_pulse", N'(err_pulse), 1);
    check("xfer_err_valid", N'(blk_valid), 0);
    check("xfer_err_cnt", N'(byte_cnt), 0);
    check("wrap_blk_count", N'(blk_count), 0);

    // Fifth block: count wraps back to 1
    exp_q.push_back(128'h505152535455565758595A5B5C5D5E5F);
    put_block(8'h50);
    cycle();
    check("wrap_blk_count5", N'(blk_count), 1);

    // Asynchronous reset in HOLD
    blk_ready = 1'b0;
    put_block(8'h60);
    check("rh_valid", N'(blk_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rh_valid_clr", N'(blk_valid), 0);
    check("rh_blk_count", N'(blk_count), 0);
    check("rh_byte_cnt", N'(byte_cnt), 0);
    check("rh_blk_data", blk_data, '0);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("rh_stays_idle", N'(blk_valid), 0);

    check("sb_drained", N'(exp_q.size()), 0);
    check("ovf_total", N'(ovf_seen), 4);
    check("err_total", N'(err_seen), 2);
    check("tmo_total", N'(tmo_seen), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Assembles the byte stream delivered by the UART receiver into 128-bit AES input blocks and hands each complete block to the AES core over a valid/ready handshake. It sits between the UART RX byte output and the AES encryption stage. It discards partial blocks on line errors or inter-byte timeout, and flags any bytes lost while a completed block waits for the AES core.

## Interface
Parameters:
- N, 128: AES block width in bits; must be a multiple of 8.
- BYTES, N/8 (16): bytes per block.
- TIMEOUT, 1000: max idle clk cycles allowed between bytes of one partial block; must be ≥ 2.
- CNT_W, 16: width of the block counter.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: system clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- rx_data, in, 8: received byte from UART RX.
- rx_valid, in, 1: one-cycle strobe, rx_data valid.
- rx_err, in, 1: parity/framing error, qualified by rx_valid.
- blk_data, out, N: assembled block; first received byte in [N-1:N-8].
- blk_valid, out, 1: blk_data holds a complete block.
- blk_ready, in, 1: AES core accepts the block.
- byte_cnt, out, $clog2(BYTES)+1: bytes in the current partial block.
- blk_count, out, CNT_W: blocks handed off since reset; wraps.
- ovf_pulse, out, 1: byte dropped because a block was pending.
- err_pulse, out, 1: rx_err byte received; partial block discarded.
- tmo_pulse, out, 1: partial block discarded on timeout.

## Operation
- States: IDLE (byte_cnt=0), FILL (0<byte_cnt<BYTES), HOLD (blk_valid=1).
- Good byte (rx_valid & !rx_err) in IDLE/FILL: blk_data <= {blk_data[N-9:0], rx_data}, byte_cnt+1. If byte_cnt reaches BYTES, go to HOLD; otherwise stay in or enter FILL.
- Error byte (rx_valid & rx_err) in IDLE/FILL: byte_cnt <= 0, go to IDLE, err_pulse=1. blk_data contents are don't-care.
- HOLD: blk_data is frozen. Any rx_valid byte is dropped and pulses ovf_pulse, except on the acceptance cycle (see below). An error byte in HOLD pulses ovf_pulse only, not err_pulse.
- Handshake: the transfer happens on the cycle blk_valid & blk_ready. blk_count increments and blk_valid drops next cycle.
- Transfer with a good byte in the same cycle: the byte is accepted as byte 1 of the next block. Next state FILL, byte_cnt=1.
- Transfer with an error byte in the same cycle: next state IDLE, err_pulse=1.
- Timeout: an idle counter clears on every accepted byte and increments each FILL cycle without rx_valid. When it reaches TIMEOUT-1 with no byte that cycle: go to IDLE, byte_cnt=0, tmo_pulse=1. The counter is inactive in IDLE and HOLD.
- A byte arriving on the expiry cycle wins: it is accepted and the counter clears.
- blk_ready is ignored when blk_valid=0.

## Timing
- Reset values: state IDLE, blk_data=0, blk_valid=0, byte_cnt=0, blk_count=0, all pulses 0, idle counter 0. Asserting reset mid-fill or in HOLD discards everything immediately.
- All outputs are registered.
- Latency: blk_valid rises 1 cycle after the clk edge sampling the 16th good byte.
- Throughput: one byte per cycle max. A back-to-back block handoff requires blk_ready high in the acceptance cycle.
- Pulses last exactly 1 cycle, registered, asserted the cycle after the causing event.
- blk_count wraps from 2^CNT_W-1 to 0.

## Test plan
- Happy path: send bytes 0x00..0x0F back-to-back with blk_ready=1. Required: blk_valid for 1 cycle, blk_data=0x000102…0E0F, blk_count=1, no pulses.
- Backpressure: fill a block with blk_ready=0, then send 3 more bytes. Required: ovf_pulse×3, blk_data unchanged. Raise blk_ready together with byte 0xAA. Required: blk_count=1, next state FILL, byte_cnt=1, blk_data[7:0]=0xAA.
- Error mid-block: send 5 good bytes, then rx_err with 0x55. Required: err_pulse=1, byte_cnt=0. Then send 16 bytes 0x10..0x1F. Required: block=0x1011…1F.
- Timeout: send 4 bytes, then idle for TIMEOUT cycles. Required: tmo_pulse exactly at expiry, byte_cnt=0. Repeat with a byte arriving on the expiry cycle. Required: no tmo_pulse, byte_cnt=5.
- Reset mid-HOLD: hold a full block, assert rst_n=0 for 1 cycle. Required: blk_valid=0, blk_count=0, byte_cnt=0 immediately, asynchronously.
- Counter wrap: with CNT_W=2, send 5 blocks. Required: blk_count sequence 1,2,3,0,1.
